r2mdc_ctrl: RTL and testbench
=============================

Name: r2mdc_ctrl

Overview:
Sequencer for an N-point radix-2 multipath delay commutator (R2MDC) FFT pipeline built from LOG2N cascaded butterfly stages. Each stage takes two streams, with one sample pair per enabled cycle. The controller does four jobs:
- generates the global pipeline advance enable;
- drives the per-stage commutator switch controls and twiddle ROM addresses;
- tags valid data and marks the first output of each frame;
- drains the pipeline on request.
The datapath (butterflies, delay lines, twiddle ROMs) is external; this block holds only control state.

Parameters:
LOG2N, 4, log2 of FFT size N. Legal range 2..10. Frame = N/2 pair-cycles.
TW_AW, LOG2N-1, twiddle ROM address width (derived, not overridable).

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample pair present this cycle
in_ready  out  1  controller accepts input pair (low only in DRAIN)
flush  in  1  single-cycle request to zero-pad and drain the pipeline
en  out  1  global advance enable for all delay lines and stage registers
sw  out  LOG2N-1  commutator cross/straight select; bit s belongs to stage s, for s = 0..LOG2N-2
tw_addr  out  LOG2N*TW_AW  packed twiddle addresses; slice s belongs to stage s
out_valid  out  1  last stage is emitting a real (non-pad) pair this cycle
out_first  out  1  out_valid pair is frame index 0
busy  out  1  state != IDLE or any tag set

Behaviour:
- Reset (async, rst_n=0) state:
  - state=IDLE, k=0, tag_sr=0.
  - Outputs: en=0, sw=0, tw_addr=0, out_valid=0, out_first=0, busy=0, in_ready=1.
  - Reset mid-frame or mid-DRAIN discards everything; there is no recovery of partial frames.
- States: IDLE, RUN, DRAIN.
  - IDLE: in_valid -> RUN, and that pair is accepted this cycle. flush with tag_sr=0 is ignored. flush with tag_sr!=0 -> DRAIN.
  - RUN: flush -> DRAIN. If flush and in_valid occur in the same cycle, the pair is accepted first, then the next state is DRAIN.
  - DRAIN: in_ready=0; in_valid and flush are ignored. Exits to IDLE at the clock edge where the post-update k==0 and tag_sr==0.
  - RUN stays in RUN while idle inputs occur (bubbles); there is no automatic drain.
- Enable: en = ((IDLE|RUN) & in_valid) | DRAIN. en is combinational from state and in_valid. All counters and tag_sr update only when en=1.
- Global index: k, LOG2N-1 bits, wraps modulo N/2. Frames are aligned so input index 0 enters at k=0.
- Stage timing:
  - Stage latency L_i = 2^(LOG2N-2-i) en-steps for i < LOG2N-1; the last stage has zero latency.
  - Stage offset D_s = N/2 - 2^(LOG2N-1-s), so D_0=0.
  - Total latency D_TOT = N/2-1. For N=16, the offsets are 0, 4, 6, 7.
- Local stage index: k_s = (k - D_s) mod N/2, combinational from k.
- Commutator select: sw[s] = bit (LOG2N-2-s) of k_s.
- Twiddle address: tw_addr[s] = (k_s mod 2^(LOG2N-1-s)) << s. The last stage address is always 0 (W=1).
- Tagging: tag_sr is D_TOT bits, shifted on en. Shift-in value = accepted pair (RUN/IDLE & in_valid); DRAIN shifts in 0.
- Output flags:
  - out_valid = en & tag_sr[D_TOT-1].
  - out_first = out_valid & (k_{LOG2N-1} == 0).
- Zero padding: in DRAIN, en=1 with pad data (the datapath muxes zero when in_ready=0). A partial frame is completed with zeros; padded outputs have out_valid=0.
- Output latency: a pair accepted on enabled cycle j appears with out_valid on enabled cycle j+D_TOT. Bubbles stretch latency in clocks, not in en-steps.
- Arithmetic: all index math is unsigned modulo N/2; the subtraction wraps naturally in LOG2N-1 bits.

Decomposition:
- Shared package r2mdc_pkg holds:
  - the function for stage offset D_s;
  - the function for twiddle-address formation;
  - the state enum {IDLE, RUN, DRAIN};
  - the localparam D_TOT.
- Natural sub-module: r2mdc_stage_seq, instantiated LOG2N times via generate. Input k; parameters LOG2N and S; outputs sw and tw_addr for that stage.
- FSM, k counter and tag_sr stay in the top.

Test Plan:
1. Reset check (N=16): assert rst_n=0 mid-RUN -> all outputs 0 immediately, in_ready=1. Release, hold idle -> en=0, busy=0.
2. Stage sequencing: 8 continuous in_valid cycles ->
   - tw_addr[0] = 0,1,...,7;
   - sw[0] = 0,0,0,0,1,1,1,1;
   - on cycle 4: k_1=0, tw_addr[1]=0, sw[1]=0;
   - tw_addr[1] on cycles 4..7 = 0,2,4,6;
   - tw_addr[3] = 0 always.
3. Output tagging: 16 continuous pairs then flush ->
   - first out_valid on 8th en cycle (index 7), out_first there and at index 15;
   - exactly 16 out_valid pulses;
   - DRAIN lasts 8 cycles; after it, IDLE, busy=0.
4. Bubbles: pattern in_valid=1,0,0,1,... -> en mirrors in_valid; k, sw, tw_addr hold during bubbles; out_valid pulse count equals accepted count.
5. Partial frame: 3 pairs then flush ->
   - DRAIN lasts 13 cycles, in_ready=0 throughout;
   - exactly 3 out_valid pulses, first with out_first=1;
   - in_valid and flush during DRAIN are ignored.
6. Edge cases:
   - flush in IDLE with empty pipe -> no state change;
   - flush+in_valid same cycle in RUN -> pair accepted, then DRAIN.

Source files
------------

// File: rtl/r2mdc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : r2mdc_pkg
//  Description : Shared types and index helpers for the R2MDC FFT sequencer.
//                Holds the controller state encoding, the per-stage delay
//                offset, the total pipeline latency and twiddle-address
//                formation.
//  Revision    : 1.0  initial release
// ============================================================================
package r2mdc_pkg;

    // Reference FFT size used for the default latency constant.
    localparam int LOG2N_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Number of en-steps between the input and the entry of stage s:
    // D_s = N/2 - 2^(LOG2N-1-s).
    function automatic int stage_offset(input int log2n, input int s);
        return (1 << (log2n - 1)) - (1 << (log2n - 1 - s));
    endfunction

    // End-to-end latency in en-steps, equal to the offset of the last stage.
    function automatic int total_latency(input int log2n);
        return (1 << (log2n - 1)) - 1;
    endfunction

    localparam int D_TOT = total_latency(LOG2N_DEFAULT);

    // Twiddle index for stage s: the low (LOG2N-1-s) bits of the local index,
    // scaled by 2^s so every stage addresses the same full-size ROM.
    function automatic int tw_form(input int ks, input int log2n, input int s);
        return (ks & ((1 << (log2n - 1 - s)) - 1)) << s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/r2mdc_stage_seq.sv
`default_nettype none
// ============================================================================
//  Module      : r2mdc_stage_seq
//  Description : Per-stage index decode. Rebases the global pair index k to
//                the stage-local index k_s = k - D_s (mod N/2) and derives the
//                commutator select and twiddle ROM address from it.
//  Ports       : k        global pair index (LOG2N-1 bits)
//                sw       commutator cross/straight select (0 on last stage)
//                tw_addr  twiddle ROM address for this stage
//  Revision    : 1.0  initial release
// ============================================================================
module r2mdc_stage_seq
    import r2mdc_pkg::*;
#(
    parameter  int LOG2N = 4,
    parameter  int S     = 0,
    localparam int KW    = LOG2N - 1
) (
    input  logic [KW-1:0] k,
    output logic          sw,
    output logic [KW-1:0] tw_addr
);

    localparam logic [KW-1:0] c_offset = KW'(stage_offset(LOG2N, S));

    logic [KW-1:0] w_ks;

    // Unsigned subtraction wraps modulo N/2 in KW bits.
    assign w_ks    = k - c_offset;
    assign tw_addr = KW'(tw_form(int'(w_ks), LOG2N, S));

    // The last stage has no commutator; its twiddle is always W^0.
    if (S < LOG2N - 1) begin : g_sw
        assign sw = w_ks[LOG2N-2-S];
    end else begin : g_sw_last
        assign sw = 1'b0;
    end

endmodule
`default_nettype wire

// File: rtl/r2mdc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : r2mdc_ctrl
//  Description : Sequencer for an N-point radix-2 multipath delay commutator
//                FFT. Generates the global advance enable, per-stage
//                commutator selects and twiddle addresses, tags real data
//                through the pipeline and drains it with zero padding.
//  Ports       : clk, rst_n        clock, async active-low reset
//                in_valid/in_ready input pair handshake (ready low in DRAIN)
//                flush             request to pad and drain the pipeline
//                en                global pipeline advance enable
//                sw[s]             commutator select of stage s
//                tw_addr[s]        twiddle address slice of stage s
//                out_valid         last stage emits a real pair
//                out_first         that pair is frame index 0
//                busy              not idle or data still in flight
//  Revision    : 1.0  initial release
// ============================================================================
module r2mdc_ctrl
    import r2mdc_pkg::*;
#(
    parameter  int LOG2N = 4,
    localparam int TW_AW = LOG2N - 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    output logic                     en,
    output logic [LOG2N-2:0]         sw,
    output logic [LOG2N*TW_AW-1:0]   tw_addr,
    output logic                     out_valid,
    output logic                     out_first,
    output logic                     busy
);

    localparam int                c_kw      = LOG2N - 1;
    localparam int                c_d_tot   = total_latency(LOG2N);
    localparam logic [c_kw-1:0]   c_d_tot_k = c_kw'(c_d_tot);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_kw-1:0]    r_k;
    logic [c_kw-1:0]    w_k_inc;
    logic [c_kw-1:0]    w_k_last;
    logic [c_d_tot-1:0] r_tag;
    logic [c_d_tot-1:0] w_tag_shift;
    logic               w_accept;
    logic [LOG2N-1:0]   w_sw_all;
    logic               w_unused_sw;

    // ------------------------------------------------------------------
    // Enable, handshake and tag shift
    // ------------------------------------------------------------------
    assign in_ready    = (r_state != DRAIN);
    assign w_accept    = in_ready & in_valid;
    // DRAIN advances every cycle so the datapath is fed zero pads.
    assign en          = w_accept | (r_state == DRAIN);
    assign w_k_inc     = r_k + c_kw'(1);
    assign w_tag_shift = (r_tag << 1) | c_d_tot'(w_accept);

    // ------------------------------------------------------------------
    // Output flags: the oldest tag bit lines up with the last stage.
    // ------------------------------------------------------------------
    assign w_k_last  = r_k - c_d_tot_k;
    assign out_valid = en & r_tag[c_d_tot-1];
    assign out_first = out_valid & (w_k_last == '0);
    assign busy      = (r_state != IDLE) | (|r_tag);

    // ------------------------------------------------------------------
    // State register and index/tag state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_tag   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (en) begin
                r_k   <= w_k_inc;
                r_tag <= w_tag_shift;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                // A flush on an empty pipe has nothing to drain.
                if (flush && (in_valid || (|r_tag))) begin
                    w_state_nxt = DRAIN;
                end else if (in_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Leave only on a frame boundary with nothing left in flight
                // so the next frame starts aligned at k=0.
                if ((w_k_inc == '0) && (w_tag_shift == '0)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-stage commutator and twiddle sequencing
    // ------------------------------------------------------------------
    for (genvar s = 0; s < LOG2N; s++) begin : g_stage
        r2mdc_stage_seq #(
            .LOG2N (LOG2N),
            .S     (s)
        ) u_seq (
            .k       (r_k),
            .sw      (w_sw_all[s]),
            .tw_addr (tw_addr[s*TW_AW +: TW_AW])
        );
    end

    assign sw          = w_sw_all[LOG2N-2:0];
    assign w_unused_sw = w_sw_all[LOG2N-1];

endmodule
`default_nettype wire

// File: tb/tb_r2mdc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_r2mdc_ctrl
//  Description : Scoreboard testbench for r2mdc_ctrl (N=16). A driver models
//                the sequencer from its index arithmetic and pushes expected
//                outputs; a monitor pops and checks out_valid/out_first.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_r2mdc_ctrl;

    localparam int LOG2N = 4;
    localparam int HALF  = 8;
    localparam int DT    = 7;
    localparam int TWW   = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        in_ready;
    logic        en;
    logic [2:0]  sw;
    logic [11:0] tw_addr;
    logic        out_valid;
    logic        out_first;
    logic        busy;

    always #5 clk = ~clk;

    r2mdc_ctrl #(.LOG2N(LOG2N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .en        (en),
        .sw        (sw),
        .tw_addr   (tw_addr),
        .out_valid (out_valid),
        .out_first (out_first),
        .busy      (busy)
    );

    typedef struct {
        int step;
        bit first;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    // Reference model: st = en-steps taken, ms = 0 idle / 1 run / 2 drain.
    int   st = 0;
    int   ms = 0;
    int   last_acc = -100;
    bit   m_en_cur = 1'b0;
    bit   mon_on = 1'b0;
    bit   s_rdy = 1'b1;
    int   ov_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (step %0d)", name, act, exp, st);
        end
    endtask

    // One clock of stimulus plus model update.
    task automatic cyc(input bit v, input bit f);
        bit          e_en, e_rdy, e_busy, acc, outst;
        int          k, ks, nms;
        logic [2:0]  e_sw;
        logic [11:0] e_tw;
        @(negedge clk);
        in_valid = v;
        flush    = f;
        #1;
        outst  = (st < last_acc + DT + 1);
        e_rdy  = (ms != 2);
        acc    = e_rdy && v;
        e_en   = acc || (ms == 2);
        e_busy = (ms != 0) || outst;
        k      = st % HALF;
        e_sw   = '0;
        e_tw   = '0;
        for (int s = 0; s < LOG2N; s++) begin
            ks = (k - (HALF - (1 << (LOG2N - 1 - s))) + HALF) % HALF;
            if (s < LOG2N - 1) e_sw[s] = ks[LOG2N-2-s];
            e_tw[s*TWW +: TWW] = 3'((ks % (1 << (LOG2N - 1 - s))) << s);
        end
        s_rdy = in_ready;
        check("en", 32'(en), 32'(e_en));
        check("in_ready", 32'(in_ready), 32'(e_rdy));
        check("busy", 32'(busy), 32'(e_busy));
        check("sw", 32'(sw), 32'(e_sw));
        check("tw_addr", 32'(tw_addr), 32'(e_tw));
        m_en_cur = e_en;
        if (acc) sb.push_back('{st + DT, (k == 0)});
        nms = ms;
        case (ms)
            0: begin
                if (f && (v || outst)) nms = 2;
                else if (v) nms = 1;
            end
            1: if (f) nms = 2;
            default: begin
                if (((st + 1) % HALF == 0) && (st + 1 >= last_acc + DT + 1)) nms = 0;
            end
        endcase
        @(posedge clk);
        if (acc) last_acc = st;
        if (e_en) st++;
        ms = nms;
    endtask

    // Run the drain with random (ignored) inputs; count in_ready-low cycles.
    task automatic drain(input int exp_len, input string name);
        int n = 0;
        int lowrdy = 0;
        while (ms == 2 && n < 64) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (s_rdy === 1'b0) lowrdy++;
            n++;
        end
        check("drain_timeout", 32'(n >= 64), 32'(0));
        if (exp_len >= 0) check(name, 32'(lowrdy), 32'(exp_len));
    endtask

    // Monitor: compares output flags against the scoreboard.
    initial begin
        bit   exp_v;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_on) begin
                exp_v = m_en_cur && (sb.size() > 0) && (sb[0].step == st);
                check("out_valid", 32'(out_valid), 32'(exp_v));
                if (out_valid === 1'b1) begin
                    ov_count++;
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("out_first", 32'(out_first), 32'(e.first));
                    end
                end else begin
                    check("out_first_idle", 32'(out_first), 32'(0));
                end
            end
        end
    end

    initial begin
        int ov0;
        // Power-on reset, then idle.
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        mon_on = 1'b1;
        cyc(0, 0);
        cyc(0, 0);

        // Asynchronous reset in the middle of a frame.
        repeat (5) cyc(1, 0);
        @(negedge clk);
        mon_on   = 1'b0;
        #2;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst_en", 32'(en), 32'(0));
        check("rst_ready", 32'(in_ready), 32'(1));
        check("rst_sw", 32'(sw), 32'(0));
        check("rst_tw", 32'(tw_addr), 32'(0));
        check("rst_ov", 32'(out_valid), 32'(0));
        check("rst_of", 32'(out_first), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        ms = 0; st = 0; last_acc = -100; m_en_cur = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        mon_on = 1'b1;
        cyc(0, 0);

        // Two full frames back to back, then flush.
        ov0 = ov_count;
        repeat (16) cyc(1, 0);
        cyc(0, 1);
        drain(8, "drain_full");
        check("pulses_full", 32'(ov_count - ov0), 32'(16));
        cyc(0, 0);

        // Bubbles between accepted pairs.
        ov0 = ov_count;
        repeat (8) begin
            cyc(1, 0);
            cyc(0, 0);
            cyc(0, 0);
        end
        cyc(0, 1);
        drain(8, "drain_bubble");
        check("pulses_bubble", 32'(ov_count - ov0), 32'(8));

        // Partial frame.
        ov0 = ov_count;
        repeat (3) cyc(1, 0);
        cyc(0, 1);
        drain(13, "drain_partial");
        check("pulses_partial", 32'(ov_count - ov0), 32'(3));

        // Flush on an empty pipe, then flush together with a pair in RUN.
        cyc(0, 1);
        cyc(0, 0);
        ov0 = ov_count;
        cyc(1, 0);
        cyc(1, 0);
        cyc(1, 1);
        drain(13, "drain_flush_valid");
        check("pulses_flush_valid", 32'(ov_count - ov0), 32'(3));

        // Random traffic with occasional flushes.
        repeat (400) cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0));
        if (ms == 1) cyc(0, 1);
        if (ms == 2) drain(-1, "drain_rand");
        cyc(0, 0);
        check("sb_empty", 32'(sb.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
